// File: rtl/fir_interp2.sv
// fir_interp2: upsample-by-2 polyphase FIR interpolator.
// Each accepted input sample produces two outputs. The even phase uses taps
// C0/C2/C4/C6 and the odd phase uses taps C1/C3/C5/C7. Both phases run over
// the same 4-deep history, using one shared multiplier for 4 MAC cycles per phase.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   x_in holds a valid sample
//   in_ready   block can accept a sample (IDLE only, low while reset is high)
//   x_in       signed 16-bit input sample
//   out_valid  y_out holds a valid output sample
//   out_ready  downstream accepts y_out
//   y_out      signed 16-bit output sample
module fir_interp2 #(
    parameter logic signed [15:0] C0    = 16'sd50,
    parameter logic signed [15:0] C1    = 16'sd100,
    parameter logic signed [15:0] C2    = 16'sd150,
    parameter logic signed [15:0] C3    = 16'sd200,
    parameter logic signed [15:0] C4    = 16'sd200,
    parameter logic signed [15:0] C5    = 16'sd150,
    parameter logic signed [15:0] C6    = 16'sd100,
    parameter logic signed [15:0] C7    = 16'sd50,
    parameter int unsigned        SHIFT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  x_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [15:0]  y_out
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 32;
    localparam int unsigned AW = 34;

    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = -AW'(32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC_E,
        S_OUT_E,
        S_MAC_O,
        S_OUT_O
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic signed [DW-1:0]  r_h0, r_h1, r_h2, r_h3;
    logic        [1:0]     r_k;
    logic signed [AW-1:0]  r_acc;
    logic signed [DW-1:0]  r_y;

    logic                  w_accept;
    logic                  w_mac;
    logic                  w_odd;
    logic signed [DW-1:0]  w_h_sel;
    logic signed [DW-1:0]  w_c_sel;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_shift;
    logic signed [DW-1:0]  w_sat;

    // Handshake and output decode from the registered state
    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_OUT_E) || (r_state == S_OUT_O);
    assign y_out     = r_y;

    assign w_accept = in_valid && in_ready;
    assign w_mac    = (r_state == S_MAC_E) || (r_state == S_MAC_O);
    assign w_odd    = (r_state == S_MAC_O);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)      w_next_state = S_MAC_E;
            S_MAC_E: if (r_k == 2'd3)   w_next_state = S_OUT_E;
            S_OUT_E: if (out_ready)     w_next_state = S_MAC_O;
            S_MAC_O: if (r_k == 2'd3)   w_next_state = S_OUT_O;
            S_OUT_O: if (out_ready)     w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    // Operand select: history tap k against the current phase's coefficient k
    always_comb begin
        w_h_sel = r_h0;
        w_c_sel = C0;
        case (r_k)
            2'd0: begin w_h_sel = r_h0; w_c_sel = w_odd ? C1 : C0; end
            2'd1: begin w_h_sel = r_h1; w_c_sel = w_odd ? C3 : C2; end
            2'd2: begin w_h_sel = r_h2; w_c_sel = w_odd ? C5 : C4; end
            default: begin w_h_sel = r_h3; w_c_sel = w_odd ? C7 : C6; end
        endcase
    end

    assign w_prod  = PW'(w_h_sel) * PW'(w_c_sel);
    assign w_sum   = r_acc + AW'(w_prod);
    assign w_shift = w_sum >>> SHIFT;

    // Clamp the scaled accumulator to the 16-bit signed range
    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = 16'sh7FFF;
        end else if (w_shift < SAT_MIN) begin
            w_sat = -16'sh8000;
        end
    end

    // History, MAC accumulator, tap counter and output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h0  <= '0;
            r_h1  <= '0;
            r_h2  <= '0;
            r_h3  <= '0;
            r_k   <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            if (w_accept) begin
                r_h3  <= r_h2;
                r_h2  <= r_h1;
                r_h1  <= r_h0;
                r_h0  <= x_in;
                r_k   <= '0;
                r_acc <= '0;
            end
            if (w_mac) begin
                if (r_k == 2'd3) begin
                    // Final tap: clear for the next phase so it starts at k=0, acc=0
                    r_y   <= w_sat;
                    r_acc <= '0;
                    r_k   <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_k   <= r_k + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed testbench for fir_interp2: reset, impulse response and timing,
// DC gain, saturation, output backpressure and reset during MAC.
module tb_fir_interp2;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] y_out;

    int n_checks = 0;
    int n_errors = 0;

    fir_interp2 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one sample at a negedge once in_ready is seen; returns after the accepting edge
    task automatic send(input logic signed [15:0] x, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                in_valid = 1'b1;
                x_in     = x;
                @(negedge clk);
                in_valid = 1'b0;
                ok       = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Take one output with out_ready high; cnt = negedges waited before out_valid
    task automatic recv(output logic signed [15:0] y, output int cnt, output bit ok);
        ok        = 1'b0;
        cnt       = 0;
        y         = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                y = y_out;
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic test_reset;
        logic signed [15:0] y;
        int  cnt;
        bit  ok;
        bit  seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || y_out !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b y_out=%0d, need 0 0 0", in_ready, out_valid, y_out);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: in_ready=%b, need 1", in_ready);
        end
        @(negedge clk);
        // Get to OUT_O with y_out=100, then reset asynchronously
        send(16'sd256, ok);
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd50) begin
            n_errors++;
            $display("FAIL reset_pre_even: got %0d ok=%b, need 50", y, ok);
        end
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen || y_out !== 16'sd100) begin
            n_errors++;
            $display("FAIL reset_pre_odd: got %0d seen=%b, need 100", y_out, seen);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || y_out !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_async: in_ready=%b out_valid=%b y_out=%0d, need 0 0 0", in_ready, out_valid, y_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_midstream_ready: in_ready=%b, need 1", in_ready);
        end
        @(negedge clk);
        // History was cleared, so a zero input gives zero in both phases
        send(16'sd0, ok);
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_hist_even: got %0d ok=%b, need 0", y, ok);
        end
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd0) begin
            n_errors++;
            $display("FAIL reset_hist_odd: got %0d ok=%b, need 0", y, ok);
        end
    endtask

    task automatic test_impulse;
        logic signed [15:0] xin [5]  = '{16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [10] = '{16'sd50, 16'sd100, 16'sd150, 16'sd200, 16'sd200,
                                         16'sd150, 16'sd100, 16'sd50, 16'sd0, 16'sd0};
        logic signed [15:0] y;
        int  cnt;
        bit  ok;
        for (int i = 0; i < 5; i++) begin
            send(xin[i], ok);
            recv(y, cnt, ok);
            n_checks++;
            if (!ok || y !== exp[2*i] || cnt != 4) begin
                n_errors++;
                $display("FAIL impulse_even[%0d]: got %0d after %0d cycles, need %0d after 4", i, y, cnt, exp[2*i]);
            end
            recv(y, cnt, ok);
            n_checks++;
            if (!ok || y !== exp[2*i+1] || cnt != 4) begin
                n_errors++;
                $display("FAIL impulse_odd[%0d]: got %0d after %0d cycles, need %0d after 4", i, y, cnt, exp[2*i+1]);
            end
        end
    endtask

    // Constant input: from the 4th sample on, both phases equal x*500 >>> 8, clamped
    task automatic test_const(input string name, input logic signed [15:0] x,
                              input int n_in, input logic signed [15:0] exp);
        logic signed [15:0] y;
        int  cnt;
        bit  ok;
        for (int i = 0; i < n_in; i++) begin
            send(x, ok);
            for (int p = 0; p < 2; p++) begin
                recv(y, cnt, ok);
                if (i >= 3) begin
                    n_checks++;
                    if (!ok || y !== exp) begin
                        n_errors++;
                        $display("FAIL %s[%0d.%0d]: got %0d, need %0d", name, i, p, y, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic signed [15:0] y;
        int  cnt;
        bit  ok;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            send(16'sd0, ok);
            recv(y, cnt, ok);
            recv(y, cnt, ok);
        end
        out_ready = 1'b0;
        send(16'sd256, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen || y_out !== 16'sd50) begin
            n_errors++;
            $display("FAIL bp_even_first: got %0d seen=%b, need 50", y_out, seen);
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            x_in     = 16'(1234 * (i + 1));
            @(negedge clk);
            n_checks++;
            if (y_out !== 16'sd50 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_stall[%0d]: y_out=%0d out_valid=%b in_ready=%b, need 50 1 0", i, y_out, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd50) begin
            n_errors++;
            $display("FAIL bp_even: got %0d, need 50", y);
        end
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd100) begin
            n_errors++;
            $display("FAIL bp_odd: got %0d, need 100", y);
        end
        // Untouched history: next zero input shifts 256 into h1
        send(16'sd0, ok);
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd150) begin
            n_errors++;
            $display("FAIL bp_hist_even: got %0d, need 150", y);
        end
        recv(y, cnt, ok);
        n_checks++;
        if (!ok || y !== 16'sd200) begin
            n_errors++;
            $display("FAIL bp_hist_odd: got %0d, need 200", y);
        end
    endtask

    task automatic test_reset_mid_mac;
        logic signed [15:0] xin [4] = '{16'sd256, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [8] = '{16'sd50, 16'sd100, 16'sd150, 16'sd200,
                                        16'sd200, 16'sd150, 16'sd100, 16'sd50};
        logic signed [15:0] y;
        int  cnt;
        bit  ok;
        out_ready = 1'b1;
        send(16'sd256, ok);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(xin[i], ok);
            for (int p = 0; p < 2; p++) begin
                recv(y, cnt, ok);
                n_checks++;
                if (!ok || y !== exp[2*i+p]) begin
                    n_errors++;
                    $display("FAIL mid_mac[%0d]: got %0d, need %0d", 2*i+p, y, exp[2*i+p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_const("dc", 16'sd1000, 5, 16'sd1953);
        test_const("sat_pos", 16'sd32767, 4, 16'sd32767);
        test_const("sat_neg", -16'sd32768, 4, -16'sd32768);
        test_backpressure();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
